// File: rtl/dmem_pkg.sv
// Shared types and default geometry for the data memory and its stream reader.
package dmem_pkg;

    localparam int unsigned DmemWidth = 32;
    localparam int unsigned DmemDepth = 256;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain
    } dmem_state_t;

endpackage

// File: rtl/dmem_stream_reader.sv
// Walks a word range of data_mem and streams it out over valid/ready.
// Optional running checksum output enabled by DMEM_STREAM_CHECKSUM_EN.
module dmem_stream_reader
    import dmem_pkg::*;
#(
    parameter int unsigned WIDTH = DmemWidth,
    parameter int unsigned DEPTH = DmemDepth,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [CNT_W-1:0] count,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] mem_a,
    input  logic [WIDTH-1:0] mem_rd,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
`ifdef DMEM_STREAM_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0] checksum
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);

    dmem_state_t      state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             capture, handshake;
    logic             sum_clr, sum_add;

    // Upper base bits are ignored: the index wraps within DEPTH.
    logic unused_base_hi;
    assign unused_base_hi = ^base[WIDTH-1:AW];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;
        done_d      = 1'b0;
        sum_clr     = 1'b0;
        sum_add     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    sum_clr = 1'b1;
                    if (count != '0) begin
                        state_d     = StRead;
                        addr_d      = base[AW-1:0];
                        remaining_d = count;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StRead: begin
                if (abort) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end else if (capture) begin
                    sum_add     = handshake;
                    data_d      = mem_rd;
                    valid_d     = 1'b1;
                    addr_d      = addr_q + AW'(1);
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        last_d  = 1'b1;
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (abort) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end else if (handshake) begin
                    sum_add = 1'b1;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        handshake = valid_q && out_ready;
        capture   = !valid_q || out_ready;
        busy      = (state_q != StIdle);
        mem_a     = WIDTH'(addr_q);
        out_data  = data_q;
        out_valid = valid_q;
        out_last  = last_q;
        done      = done_q;
    end

`ifdef DMEM_STREAM_CHECKSUM_EN
    logic [WIDTH-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else if (sum_clr) begin
            sum_q <= '0;
        end else if (sum_add) begin
            sum_q <= sum_q + data_q;
        end
    end

    assign checksum = sum_q;
`else
    logic unused_sum;
    assign unused_sum = sum_clr ^ sum_add;
`endif

endmodule

// File: doc/dmem_stream_reader.md
# dmem_stream_reader

Sequential read-side master for the single-cycle MIPS data memory. On a start pulse it walks a word range of `data_mem` through the A/RD port and presents each word on a valid/ready output stream. It sits beside the core, muxed onto the data-memory address port when the core is halted, and serves memory dumps, self-check and debug readback of what the store path wrote.

## Interface
- `WIDTH`, 32, data and address width, matching `data_mem`
- `DEPTH`, 256, memory depth in words; power of two
- `CNT_W`, 16, width of the word-count input

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous reset, active-high
- `start`  in  1  one-cycle request; ignored while `busy`
- `base`  in  WIDTH  first word index; only the low log2(DEPTH) bits are used
- `count`  in  CNT_W  number of words to read
- `abort`  in  1  terminates the transfer immediately
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle pulse after the final handshake
- `mem_a`  out  WIDTH  word index to `data_mem.A`
- `mem_rd`  in  WIDTH  combinational read data from `data_mem.RD`
- `out_data`  out  WIDTH  streamed word
- `out_valid`  out  1  `out_data` is valid
- `out_ready`  in  1  consumer accepts the word
- `out_last`  out  1  qualifies the final word
- `checksum`  out  WIDTH  running sum; present only with the macro

## Operation
- FSM states: IDLE, READ, DRAIN.
- IDLE + `start`:
  - `count`≠0: latch `addr`=`base` mod DEPTH and `remaining`=`count`, go to READ.
  - `count`=0: pulse `done` next cycle and stay in IDLE.
- READ:
  - `mem_a`=`addr` with upper bits zero.
  - Capture condition: `!out_valid || out_ready`. On capture, register `mem_rd` into `out_data`, set `out_valid`, advance `addr`=(`addr`+1) mod DEPTH and decrement `remaining`.
  - Capturing the word with `remaining`=1 sets `out_last` and moves to DRAIN.
- DRAIN: waits for the `out_valid && out_ready` handshake, then clears `out_valid`/`out_last`, pulses `done` and returns to IDLE.
- Backpressure: while `out_valid && !out_ready`, `out_data`, `mem_a` and `addr` hold. No word is lost or duplicated.
- `abort` in any non-IDLE state takes priority over capture. Next cycle: IDLE, `out_valid`=0, `out_last`=0, `busy`=0, no `done`.
- `start` while `busy` has no effect. Simultaneous `start`+`abort` in IDLE: `abort` wins.
- `mem_rd` is sampled at the capture edge. Memory writes after that edge are not reflected in the held word.
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `mem_a`=0, `checksum`=0, state IDLE.

## Timing
- `start` sampled at edge N: after N, `busy`=1 and `mem_a`=`base`.
- First word is valid after edge N+1.
- With `out_ready` held high, word k is valid after edge N+1+k: one word per cycle.
- Final handshake at edge M: after M, `done`=1 for one cycle and `busy`=0. `done` is 0 again after M+1.
- Earliest restart: `start` sampled at edge M+1.
- `count`=0: `done`=1 after edge N; `busy` never asserts.
- Reset mid-transfer: all outputs take reset values after the reset edge.

## Configuration
- `DMEM_STREAM_CHECKSUM_EN`:
  - Defined: the `checksum` port exists. It is cleared on accepted `start`, adds each handshaked word mod 2^WIDTH, and holds its value after `done` until the next `start`. Abort leaves the partial sum.
  - Undefined: the port and adder are absent and behaviour is otherwise identical.

## Structure
- Shared package `dmem_pkg`:
  - `dmem_state_t` enum (IDLE, READ, DRAIN).
  - Default `WIDTH`/`DEPTH` constants shared with `data_mem`.
- Output register and FSM are inline; no sub-module is needed. The address/count datapath is under 150 lines.

## Test plan
Memory preloaded with mem[i]=i+1, i=0..255.
- `base`=0, `count`=4, ready high -> `out_data` 1,2,3,4 on consecutive cycles; `out_last` with 4; `done` one cycle after; `checksum`=10.
- `base`=0, `count`=3, `out_ready` low 3 cycles after the first valid -> word 1 held stable and `mem_a`=1 held; then 2,3 follow; no duplicates.
- `base`=254, `count`=4 -> `mem_a` 254,255,0,1; data 255,256,1,2.
- `count`=0 -> `done` after 1 cycle; `out_valid` never asserts.
- `abort` after the second word of `count`=8, then `rst` during a second transfer -> `out_valid`=0 and `busy`=0 next cycle; no `done`.
- `start` with `base`=100 during an active transfer -> ignored; stream continues from the original addresses.
